// File: rtl/cskips_20bit_seq.sv
// cskips_20bit_seq: multi-cycle carry-skip subtractor.
// Computes i_min - i_sub as i_min + ~i_sub + 1, one 4-bit block per clock.
// A block whose propagate bits are all set passes its incoming carry straight
// through, and the number of such blocks is reported with the result.
// Operands are taken on a valid/ready handshake; the result is held under
// backpressure until the consumer accepts it.
module cskips_20bit_seq #(
   parameter int WIDTH = 20,
   parameter int CW    = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_min,
   input  logic [WIDTH-1:0] i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow,
   output logic             o_ovf,
   output logic [CW-1:0]    o_skip_cnt
);

   localparam int            NB       = WIDTH / 4;
   localparam logic [CW-1:0] LAST_BLK = CW'(NB - 1);
   localparam logic [CW-1:0] ONE_CW   = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q,    state_d;
   logic [WIDTH-1:0]   a_q,        a_d;        // latched minuend
   logic [WIDTH-1:0]   b_q,        b_d;        // latched inverted subtrahend
   logic [WIDTH-1:0]   diff_q,     diff_d;     // difference under construction
   logic               carry_q,    carry_d;
   logic [CW-1:0]      blk_q,      blk_d;
   logic [CW-1:0]      skip_q,     skip_d;
   logic [WIDTH-1:0]   o_diff_q,   o_diff_d;
   logic               o_borrow_q, o_borrow_d;
   logic               o_ovf_q,    o_ovf_d;
   logic [CW-1:0]      o_skip_q,   o_skip_d;
   logic               o_valid_q,  o_valid_d;
   logic               o_ready_q,  o_ready_d;

   logic [CW+1:0]      idx_s;
   logic [3:0]         a_blk_s;
   logic [3:0]         b_blk_s;
   logic [3:0]         p_s;
   logic [4:0]         sum_s;
   logic               skip_s;

   // Current block slice: propagate bits and the 5-bit ripple sum (bit 4 is the ripple carry-out).
   always_comb begin
      idx_s   = {blk_q, 2'b00};
      a_blk_s = a_q[idx_s +: 4];
      b_blk_s = b_q[idx_s +: 4];
      p_s     = a_blk_s ^ b_blk_s;
      sum_s   = {1'b0, a_blk_s} + {1'b0, b_blk_s} + {4'b0000, carry_q};
      skip_s  = &p_s;
   end

   // Next-state logic for the handshake FSM, block datapath and result registers.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      diff_d     = diff_q;
      carry_d    = carry_q;
      blk_d      = blk_q;
      skip_d     = skip_q;
      o_diff_d   = o_diff_q;
      o_borrow_d = o_borrow_q;
      o_ovf_d    = o_ovf_q;
      o_skip_d   = o_skip_q;

      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               a_d     = i_min;
               b_d     = ~i_sub;
               diff_d  = {WIDTH{1'b0}};
               carry_d = 1'b1;
               blk_d   = {CW{1'b0}};
               skip_d  = {CW{1'b0}};
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            diff_d[idx_s +: 4] = sum_s[3:0];
            // When every bit propagates, the ripple carry-out equals the carry-in,
            // so taking the bypass never changes the arithmetic result.
            if (skip_s) begin
               carry_d = carry_q;
               skip_d  = skip_q + ONE_CW;
            end else begin
               carry_d = sum_s[4];
               skip_d  = skip_q;
            end
            if (blk_q == LAST_BLK) begin
               state_d    = ST_DONE;
               blk_d      = blk_q;
               o_diff_d   = diff_d;
               o_borrow_d = ~carry_d;
               // Operand signs differ (b holds ~sub) and result sign differs from minuend.
               o_ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (diff_d[WIDTH-1] != a_q[WIDTH-1]);
               o_skip_d   = skip_d;
            end else begin
               state_d = ST_BUSY;
               blk_d   = blk_q + ONE_CW;
            end
         end
         ST_DONE: begin
            if (i_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      o_valid_d = (state_d == ST_DONE);
      o_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         a_q        <= {WIDTH{1'b0}};
         b_q        <= {WIDTH{1'b0}};
         diff_q     <= {WIDTH{1'b0}};
         carry_q    <= 1'b0;
         blk_q      <= {CW{1'b0}};
         skip_q     <= {CW{1'b0}};
         o_diff_q   <= {WIDTH{1'b0}};
         o_borrow_q <= 1'b0;
         o_ovf_q    <= 1'b0;
         o_skip_q   <= {CW{1'b0}};
         o_valid_q  <= 1'b0;
         o_ready_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         diff_q     <= diff_d;
         carry_q    <= carry_d;
         blk_q      <= blk_d;
         skip_q     <= skip_d;
         o_diff_q   <= o_diff_d;
         o_borrow_q <= o_borrow_d;
         o_ovf_q    <= o_ovf_d;
         o_skip_q   <= o_skip_d;
         o_valid_q  <= o_valid_d;
         o_ready_q  <= o_ready_d;
      end
   end

   assign o_ready    = o_ready_q;
   assign o_valid    = o_valid_q;
   assign o_diff     = o_diff_q;
   assign o_borrow   = o_borrow_q;
   assign o_ovf      = o_ovf_q;
   assign o_skip_cnt = o_skip_q;

endmodule

// File: tb/tb_cskips_20bit_seq.sv
// Directed and reference-checked bench for cskips_20bit_seq.
module tb_cskips_20bit_seq;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [19:0] i_min;
   logic [19:0] i_sub;
   logic        o_valid;
   logic        i_ready;
   logic [19:0] o_diff;
   logic        o_borrow;
   logic        o_ovf;
   logic [2:0]  o_skip_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   cskips_20bit_seq #(.WIDTH(20), .CW(3)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_min      (i_min),
      .i_sub      (i_sub),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_diff     (o_diff),
      .o_borrow   (o_borrow),
      .o_ovf      (o_ovf),
      .o_skip_cnt (o_skip_cnt)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!o_ready && n < 30) begin
         tick();
         n++;
      end
      check_eq("ready_wait", 32'(o_ready), 32'd1);
   endtask

   // Runs one operation; i_ready is held low for 'stall' cycles once the result appears.
   task automatic do_op(input string tag, input logic [19:0] mn, input logic [19:0] sb,
                        input int stall, input logic [19:0] e_diff, input logic e_bor,
                        input logic e_ovf, input logic [2:0] e_skip);
      int cyc;
      i_min   = mn;
      i_sub   = sb;
      i_valid = 1'b1;
      i_ready = (stall == 0);
      wait_ready();
      tick();
      i_valid = 1'b0;
      i_min   = ~mn;
      i_sub   = mn;
      cyc = 0;
      while (!o_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check_eq({tag, "_latency"}, 32'(cyc), 32'd5);
      check_eq({tag, "_diff"}, 32'(o_diff), 32'(e_diff));
      check_eq({tag, "_borrow"}, 32'(o_borrow), 32'(e_bor));
      check_eq({tag, "_ovf"}, 32'(o_ovf), 32'(e_ovf));
      check_eq({tag, "_skip"}, 32'(o_skip_cnt), 32'(e_skip));
      check_eq({tag, "_ready_in_done"}, 32'(o_ready), 32'd0);
      for (int s = 0; s < stall; s++) begin
         tick();
         check_eq({tag, "_stall_valid"}, 32'(o_valid), 32'd1);
         check_eq({tag, "_stall_ready"}, 32'(o_ready), 32'd0);
         check_eq({tag, "_stall_diff"}, 32'(o_diff), 32'(e_diff));
         check_eq({tag, "_stall_skip"}, 32'(o_skip_cnt), 32'(e_skip));
      end
      i_ready = 1'b1;
      tick();
      check_eq({tag, "_post_valid"}, 32'(o_valid), 32'd0);
      check_eq({tag, "_post_ready"}, 32'(o_ready), 32'd1);
   endtask

   function automatic logic [2:0] ref_skip(input logic [19:0] mn, input logic [19:0] sb);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (mn[4*i +: 4] == sb[4*i +: 4]) c = c + 3'd1;
      end
      return c;
   endfunction

   initial begin
      logic [19:0] cur_min, cur_sub, nxt_min, nxt_sub, e_diff;
      logic        e_ovf;
      int          cyc;
      int          n_res;

      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_min   = 20'h00000;
      i_sub   = 20'h00000;
      tick();
      tick();
      check_eq("rst_ready", 32'(o_ready), 32'd1);
      check_eq("rst_valid", 32'(o_valid), 32'd0);
      check_eq("rst_diff", 32'(o_diff), 32'd0);
      check_eq("rst_skip", 32'(o_skip_cnt), 32'd0);
      rst_n = 1'b1;
      tick();

      do_op("t1", 20'h12345, 20'h01234, 0, 20'h11111, 1'b0, 1'b0, 3'd0);
      do_op("t2", 20'h00000, 20'h00001, 0, 20'hFFFFF, 1'b1, 1'b0, 3'd4);
      do_op("t3", 20'h7FFFF, 20'hFFFFF, 0, 20'h80000, 1'b1, 1'b1, 3'd4);
      do_op("t4", 20'hABCDE, 20'hABCDE, 3, 20'h00000, 1'b0, 1'b0, 3'd5);
      do_op("t5", 20'h00000, 20'h00001, 0, 20'hFFFFF, 1'b1, 1'b0, 3'd4);

      // Reset during the third BUSY cycle.
      i_min   = 20'h12345;
      i_sub   = 20'h01234;
      i_valid = 1'b1;
      wait_ready();
      tick();
      i_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("mrst_valid", 32'(o_valid), 32'd0);
      check_eq("mrst_ready", 32'(o_ready), 32'd1);
      check_eq("mrst_diff", 32'(o_diff), 32'd0);
      check_eq("mrst_borrow", 32'(o_borrow), 32'd0);
      check_eq("mrst_ovf", 32'(o_ovf), 32'd0);
      check_eq("mrst_skip", 32'(o_skip_cnt), 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check_eq("mrst_no_result", 32'(o_valid), 32'd0);
      end
      // Upper three nibble pairs are equal (0 vs 0), so three blocks skip.
      do_op("t6", 20'h00010, 20'h00001, 0, 20'h0000F, 1'b0, 1'b0, 3'd3);

      // Back-to-back with i_valid held high; operands change right after each accept.
      i_ready = 1'b1;
      cur_min = 20'($urandom);
      cur_sub = 20'($urandom);
      i_min   = cur_min;
      i_sub   = cur_sub;
      i_valid = 1'b1;
      n_res   = 0;
      for (int n = 0; n < 24; n++) begin
         wait_ready();
         tick();
         nxt_min = 20'($urandom);
         nxt_sub = nxt_min;
         for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 1) == 1) nxt_sub[4*i +: 4] = 4'($urandom_range(0, 15));
         end
         if (n % 4 == 3) nxt_sub = 20'($urandom);
         i_min = nxt_min;
         i_sub = nxt_sub;
         cyc = 0;
         while (!o_valid && cyc < 20) begin
            tick();
            cyc++;
         end
         check_eq("rnd_latency", 32'(cyc), 32'd5);
         e_diff = cur_min - cur_sub;
         e_ovf  = (cur_min[19] != cur_sub[19]) && (e_diff[19] != cur_min[19]);
         check_eq("rnd_diff", 32'(o_diff), 32'(e_diff));
         check_eq("rnd_borrow", 32'(o_borrow), 32'(cur_min < cur_sub));
         check_eq("rnd_ovf", 32'(o_ovf), 32'(e_ovf));
         check_eq("rnd_skip", 32'(o_skip_cnt), 32'(ref_skip(cur_min, cur_sub)));
         if (o_valid) n_res++;
         tick();
         check_eq("rnd_single_done", 32'(o_valid), 32'd0);
         cur_min = nxt_min;
         cur_sub = nxt_sub;
      end
      i_valid = 1'b0;
      check_eq("rnd_result_count", 32'(n_res), 32'd24);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
